// File: rtl/puf128_resp_streamer.sv
// Captures the PUF response on a puf_done rising edge and streams it MSW-first as WORD_W words.
// Optional build macro PUF_STREAM_CRC_EN appends a CRC-16/CCITT-FALSE trailer word.
module puf128_resp_streamer #(
    parameter int unsigned RESP_W = 128,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RESP_W-1:0] puf_out,
    input  logic              puf_done,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned NWORDS = RESP_W / WORD_W;
    localparam int unsigned CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

`ifdef PUF_STREAM_CRC_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_TRAIL} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND} state_t;
`endif

    state_t            state_q, state_d;
    logic [RESP_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [WORD_W-1:0] cur_word;
    logic              rise;

`ifdef PUF_STREAM_CRC_EN
    logic [15:0] crc_q, crc_d;

    // CRC-16/CCITT-FALSE, one data bit per step, MSB of the word first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [WORD_W-1:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            if (c[15] ^ data[WORD_W-1-i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                          c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PUF_STREAM_CRC_EN
            crc_q     <= '1;
`endif
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef PUF_STREAM_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

    always_comb begin
        cur_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (cnt_q == CNT_W'(i)) cur_word = shadow_q[RESP_W-1-i*WORD_W -: WORD_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        done_d    = puf_done;
        overrun_d = overrun_q;
`ifdef PUF_STREAM_CRC_EN
        crc_d     = crc_q;
`endif
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        rise      = puf_done & ~done_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_SEND;
                    shadow_d = puf_out;
                    cnt_d    = '0;
`ifdef PUF_STREAM_CRC_EN
                    crc_d    = '1;
`endif
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = cur_word;
`ifndef PUF_STREAM_CRC_EN
                out_last  = (cnt_q == LAST_IDX);
`endif
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef PUF_STREAM_CRC_EN
                    crc_d = crc16_word(crc_q, cur_word);
                    if (cnt_q == LAST_IDX) state_d = ST_TRAIL;
`else
                    if (cnt_q == LAST_IDX) state_d = ST_IDLE;
`endif
                end
            end
`ifdef PUF_STREAM_CRC_EN
            ST_TRAIL: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = WORD_W'(crc_q);
                out_last  = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // An edge during the final accept still sees a non-idle state, so it counts as overrun.
        if (rise && state_q != ST_IDLE) overrun_d = 1'b1;
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_puf128_resp_streamer.sv
// Directed table-driven bench for puf128_resp_streamer (default and PUF_STREAM_CRC_EN builds).
module tb_puf128_resp_streamer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] puf_out = '0;
    logic         puf_done = 1'b0;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         busy;
    logic         overrun;

    int unsigned total = 0;
    int unsigned bad = 0;

`ifdef PUF_STREAM_CRC_EN
    localparam int unsigned NW = 9;
`else
    localparam int unsigned NW = 8;
`endif

    typedef struct {
        logic [127:0] resp;
        logic [15:0]  w [8];
        int unsigned  stall;
        int unsigned  glitch_k;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    puf128_resp_streamer #(.RESP_W(128), .WORD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .puf_out(puf_out), .puf_done(puf_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte-oriented CRC-16/CCITT-FALSE over the frame bytes, high byte of each word first.
    function automatic logic [15:0] crc_model(input logic [15:0] w [8]);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            b = (k % 2 == 0) ? w[k/2][15:8] : w[k/2][7:0];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic run_frame(input vec_t v);
        logic [15:0] exp_w [9];
        int unsigned k, cyc, gk;
        bit raised, acc;
        for (int i = 0; i < 8; i++) exp_w[i] = v.w[i];
        exp_w[8] = crc_model(v.w);
        k = 0; cyc = 0; raised = 0;
        gk = (v.glitch_k == 99) ? NW - 1 : v.glitch_k;
        @(negedge clk);
        check("idle_before", out_valid, 0);
        puf_out  = v.resp;
        puf_done = 1'b1;
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        while (k < NW && cyc < 200) begin
            out_ready = (v.stall != 0) ? ((cyc % 3) == 0) : 1'b1;
            if (gk != 0 && !raised) begin
                if (k == 1) puf_done = 1'b0;
                if (k == gk && out_ready) begin
                    puf_done = 1'b1;
                    puf_out  = ~v.resp;
                    raised   = 1;
                end
            end
            check("word_valid", out_valid, 1);
            check("word_data", out_data, exp_w[k]);
            check("word_last", out_last, (k == NW - 1));
            check("word_busy", busy, 1);
            acc = out_ready;
            @(negedge clk);
            if (acc) k++;
            cyc++;
        end
        if (cyc >= 200) check("frame_timeout", 1, 0);
        out_ready = 1'b0;
        check("end_valid", out_valid, 0);
        check("end_busy", busy, 0);
        check("end_last", out_last, 0);
    endtask

    task automatic do_reset();
        puf_done  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_overrun", overrun, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned vcnt;

        vecs[0].resp = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        vecs[0].w = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
        vecs[0].stall = 0; vecs[0].glitch_k = 0;
        vecs[1] = vecs[0];
        vecs[1].stall = 1;
        vecs[2].resp = 128'h5468697349734E6F74576F726B696E67;
        vecs[2].w = '{16'h5468, 16'h6973, 16'h4973, 16'h4E6F, 16'h7457, 16'h6F72, 16'h6B69, 16'h6E67};
        vecs[2].stall = 1; vecs[2].glitch_k = 0;
        vecs[3] = vecs[0];
        vecs[3].glitch_k = 3;
        vecs[4] = vecs[2];
        vecs[4].stall = 0; vecs[4].glitch_k = 99;

        repeat (3) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_last", out_last, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
            check("overrun_after_frame", overrun, (vecs[i].glitch_k != 0));
            vcnt = 0;
            repeat (5) begin
                @(negedge clk);
                if (out_valid) vcnt++;
            end
            check("no_retrigger", vcnt, 0);
            check("overrun_sticky", overrun, (vecs[i].glitch_k != 0));
            if (vecs[i].glitch_k != 0) do_reset();
            puf_done = 1'b0;
            @(negedge clk);
        end

        // puf_done held high long after a frame, then a fresh edge with new data
        run_frame(vecs[0]);
        vcnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("held_high_one_frame", vcnt, 0);
        puf_done = 1'b0;
        @(negedge clk);
        run_frame(vecs[2]);
        check("held_high_overrun", overrun, 0);

        // reset asserted while word 5 is on the bus
        puf_done = 1'b0;
        @(negedge clk);
        puf_out  = vecs[0].resp;
        puf_done = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_word5", out_data, 16'hAABB);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_data", out_data, 0);
        check("abort_last", out_last, 0);
        puf_done  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy) vcnt++;
        end
        check("abort_stays_idle", vcnt, 0);
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
